sonar_ping_timer: RTL

//  Ultrasonic ping generator and echo-time measurer, clocked by the rPLL fast clock (27 MHz x61/5 = 329.4 MHz).
//  On a start request it drives a complementary square-wave burst to the transducer driver.
//  It then blanks out ringing and counts microsecond ticks until the echo comparator fires or the timeout expires.

---
 rtl/sonar_pkg.sv | 22 ++
 rtl/sonar_ping_timer_if.sv | 34 +++
 rtl/sonar_tick_div.sv | 36 +++
 rtl/sonar_ping_timer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar ping timer.
//   state_e    : controller states (IDLE, BURST, BLANK, LISTEN)
//   calc_half  : clocks per tone half-period, floor(clk_hz / (2 * tone_hz))
//   calc_tdiv  : clocks per measurement tick, floor(clk_hz / tick_hz)
package sonar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST  = 2'd1,
    BLANK  = 2'd2,
    LISTEN = 2'd3
  } state_e;

  function automatic int unsigned calc_half(int unsigned clk_hz, int unsigned tone_hz);
    return clk_hz / (2 * tone_hz);
  endfunction

  function automatic int unsigned calc_tdiv(int unsigned clk_hz, int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/sonar_ping_timer_if.sv
// Control/result bundle between the ping timer and its neighbours.
//   start      : ping request (controller -> timer)
//   echo_in    : raw asynchronous echo comparator output (analog front end -> timer)
//   busy       : timer not idle
//   tx_p/tx_n  : complementary transducer drive
//   dist_valid : one-cycle strobe, dist_ticks holds a fresh echo distance
//   dist_ticks : ticks from burst end to echo (or DW'(TIMEOUT_TICKS) on timeout)
//   timeout    : one-cycle strobe, no echo seen
// Modports: master = the side requesting pings and feeding the echo,
//           slave  = the ping timer itself.
interface sonar_ping_timer_if #(
  parameter int unsigned DW = 16
) ();

  logic          start;
  logic          echo_in;
  logic          busy;
  logic          tx_p;
  logic          tx_n;
  logic          dist_valid;
  logic [DW-1:0] dist_ticks;
  logic          timeout;

  modport master (
    output start, echo_in,
    input  busy, tx_p, tx_n, dist_valid, dist_ticks, timeout
  );

  modport slave (
    input  start, echo_in,
    output busy, tx_p, tx_n, dist_valid, dist_ticks, timeout
  );

endinterface

// File: rtl/sonar_tick_div.sv
// Measurement tick prescaler: counts 0..TDIV-1 and emits a one-cycle tick
// on the last count. A synchronous clear holds it at 0 so the first tick
// lands exactly TDIV clocks after clear is released.
//   clk  : clock
//   rst  : synchronous reset, active-high
//   clr  : synchronous clear (hold prescaler at 0, no tick)
//   tick : one-cycle tick enable
module sonar_tick_div #(
  parameter int unsigned TDIV = 329
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (TDIV > 1) ? $clog2(TDIV) : 1;
  localparam logic [W-1:0] LAST = W'(TDIV - 1);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = ~clr && (cnt_q == LAST);

endmodule

// File: rtl/sonar_ping_timer.sv
// Ultrasonic ping generator and echo-time measurer.
// A start request in IDLE launches a complementary square-wave burst of
// BURST_CYCLES tone periods. After the burst, microsecond ticks are counted;
// echoes are ignored for BLANK_TICKS (transducer ringing), then the first
// synchronized rising echo edge reports the tick count, or TIMEOUT_TICKS
// elapse and a timeout is reported.
//   clk : fast PLL clock
//   rst : synchronous reset, active-high
//   bus : sonar_ping_timer_if.slave (start, echo_in in; busy, tx_p, tx_n,
//         dist_valid, dist_ticks, timeout out)
module sonar_ping_timer
  import sonar_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 329400000,
  parameter int unsigned TONE_HZ       = 40000,
  parameter int unsigned BURST_CYCLES  = 8,
  parameter int unsigned TICK_HZ       = 1000000,
  parameter int unsigned BLANK_TICKS   = 200,
  parameter int unsigned TIMEOUT_TICKS = 30000,
  parameter int unsigned DW            = 16
) (
  input  logic               clk,
  input  logic               rst,
  sonar_ping_timer_if.slave  bus
);

  localparam int unsigned HALF   = calc_half(CLK_HZ, TONE_HZ);
  localparam int unsigned TDIV   = calc_tdiv(CLK_HZ, TICK_HZ);
  localparam int unsigned NHALF  = 2 * BURST_CYCLES;
  localparam int unsigned HW     = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned IW     = (NHALF > 1) ? $clog2(NHALF) : 1;

  localparam logic [HW-1:0] HALF_LAST  = HW'(HALF - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NHALF - 1);
  localparam logic [DW-1:0] BLANK_END  = DW'(BLANK_TICKS);
  localparam logic [DW-1:0] TIMEOUT_AT = DW'(TIMEOUT_TICKS);

  state_e        state_q, state_d;
  logic [HW-1:0] half_cnt_q;   // clocks within current half-period
  logic [IW-1:0] half_idx_q;   // half-period index; bit 0 selects the phase
  logic [DW-1:0] tick_cnt_q;
  logic [DW-1:0] tick_nxt;
  logic [2:0]    echo_sync_q;  // [0],[1] synchronizer, [2] previous synced value
  logic          echo_rise;
  logic          tick;
  logic          counting;
  logic          half_wrap;

  logic          dist_valid_q, dist_valid_d;
  logic          timeout_q, timeout_d;
  logic [DW-1:0] dist_ticks_q, dist_ticks_d;

  // Echo comparator is asynchronous to clk: two flops for metastability,
  // a third to remember the previous synchronized level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_sync_q <= '0;
    end else begin
      echo_sync_q <= {echo_sync_q[1:0], bus.echo_in};
    end
  end

  assign echo_rise = echo_sync_q[1] & ~echo_sync_q[2];

  assign counting  = (state_q == BLANK) || (state_q == LISTEN);
  assign half_wrap = (half_cnt_q == HALF_LAST);

  // Prescaler is held cleared outside BLANK/LISTEN so tick timing is
  // referenced to the first cycle after the burst.
  sonar_tick_div #(
    .TDIV (TDIV)
  ) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (~counting),
    .tick (tick)
  );

  assign tick_nxt = tick_cnt_q + DW'(tick);

  // Burst timing: HALF clocks per half-period, NHALF half-periods per ping.
  always_ff @(posedge clk) begin
    if (rst || (state_q != BURST)) begin
      half_cnt_q <= '0;
      half_idx_q <= '0;
    end else if (half_wrap) begin
      half_cnt_q <= '0;
      half_idx_q <= half_idx_q + 1'b1;
    end else begin
      half_cnt_q <= half_cnt_q + 1'b1;
    end
  end

  // Tick counter never passes TIMEOUT_TICKS: the FSM leaves LISTEN on the
  // tick that reaches it, which clears the counter.
  always_ff @(posedge clk) begin
    if (rst || !counting) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= tick_nxt;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    dist_valid_d = 1'b0;
    timeout_d    = 1'b0;
    dist_ticks_d = dist_ticks_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = BURST;
      end
      BURST: begin
        if (half_wrap && (half_idx_q == IDX_LAST)) state_d = BLANK;
      end
      BLANK: begin
        if (tick && (tick_nxt == BLANK_END)) state_d = LISTEN;
      end
      LISTEN: begin
        // Echo is checked first so a coincident timeout loses.
        if (echo_rise) begin
          dist_valid_d = 1'b1;
          dist_ticks_d = tick_cnt_q;
          state_d      = IDLE;
        end else if (tick && (tick_nxt == TIMEOUT_AT)) begin
          timeout_d    = 1'b1;
          dist_ticks_d = TIMEOUT_AT;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dist_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      dist_ticks_q <= '0;
    end else begin
      state_q      <= state_d;
      dist_valid_q <= dist_valid_d;
      timeout_q    <= timeout_d;
      dist_ticks_q <= dist_ticks_d;
    end
  end

  // Strobes are registered alongside the return to IDLE, so busy drops in
  // the same cycle the strobe is visible.
  assign bus.busy       = (state_q != IDLE);
  assign bus.tx_p       = (state_q == BURST) & ~half_idx_q[0];
  assign bus.tx_n       = (state_q == BURST) &  half_idx_q[0];
  assign bus.dist_valid = dist_valid_q;
  assign bus.timeout    = timeout_q;
  assign bus.dist_ticks = dist_ticks_q;

endmodule
